// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package seven_seg_pkg;

    // Active-high {g,f,e,d,c,b,a} patterns, entry i is hex digit i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    // All segments dark, active-high form.
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Convert an active-high pattern to the board's drive polarity.
    function automatic logic [6:0] apply_polarity(input logic [6:0] pat, input bit active_low);
        return active_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-high seven-segment pattern, purely combinational.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] pat_o
);

    assign pat_o = SEG_TABLE[val_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for N_DIGITS seven-segment digits: holds one hex
// nibble per digit, rotates through them every REFRESH_DIV cycles and drives
// registered segment/anode outputs.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        wr_en,
    input  logic [$clog2(N_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                  wr_data,
    input  logic [N_DIGITS-1:0]         blank_mask,
    output logic [6:0]                  seg,
    output logic [N_DIGITS-1:0]         anode,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx
);

    localparam int AW = $clog2(N_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [AW:0]           N_LIMIT   = (AW+1)'(N_DIGITS);
    localparam logic [AW-1:0]         IDX_LAST  = AW'(N_DIGITS - 1);
    localparam logic [PW-1:0]         PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [N_DIGITS-1:0]   ANODE_OFF = {N_DIGITS{ACTIVE_LOW}};

    if (N_DIGITS < 2 || N_DIGITS > 16) begin : g_bad_n_digits
        $error("seven_seg_scan: N_DIGITS must be in 2..16");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seven_seg_scan: REFRESH_DIV must be at least 2");
    end

    logic [3:0]          digits_q [N_DIGITS];
    logic [PW-1:0]       presc_q, presc_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] anode_q, anode_d;
    logic                wr_hit;
    logic                lit;
    logic [6:0]          pat;

    // Addresses beyond the last digit (non power-of-two counts) are dropped.
    assign wr_hit = wr_en && ({1'b0, wr_addr} < N_LIMIT);

    // Digit storage: one nibble per digit, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) digits_q[i] <= 4'h0;
        end else if (wr_hit) begin
            digits_q[wr_addr] <= wr_data;
        end
    end

    // Prescaler and scan index advance only while enabled; both hold otherwise.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (en) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    seven_seg_decoder u_decoder (
        .val_i (digits_q[idx_q]),
        .pat_o (pat)
    );

    // Next output drive from the current digit, mask and enable.
    always_comb begin
        logic [N_DIGITS-1:0] act;
        lit = en && !blank_mask[idx_q];
        act = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            act[i] = lit && (idx_q == AW'(i));
        end
        seg_d   = apply_polarity(lit ? pat : SEG_OFF, ACTIVE_LOW);
        anode_d = ACTIVE_LOW ? ~act : act;
    end

    // Output register: outputs lag the scan state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q   <= apply_polarity(SEG_OFF, ACTIVE_LOW);
            anode_q <= ANODE_OFF;
        end else begin
            seg_q   <= seg_d;
            anode_q <= anode_d;
        end
    end

    assign seg       = seg_q;
    assign anode     = anode_q;
    assign digit_idx = idx_q;

endmodule
